audio_clip_player: RTL
======================

AUDIO_CLIP_PLAYER -- requirements
Module: audio_clip_player

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, audio RAM address width.
REQ-002 SHALL have parameter CLIP0_START, default 14'h0000, first word address of clip 0.
REQ-003 SHALL have parameter CLIP0_END, default 14'h1FFF, last word address of clip 0 (inclusive).
REQ-004 SHALL have parameter CLIP1_START, default 14'h2000, first word address of clip 1.
REQ-005 SHALL have parameter CLIP1_END, default 14'h3FFF, last word address of clip 1 (inclusive).
REQ-006 SHALL have port Clk  input  1  system clock (50 MHz).
REQ-007 SHALL have port Reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port lrclk  input  1  codec frame clock, asynchronous to Clk; one sample per rising edge.
REQ-009 SHALL have port trig  input  2  play requests, level signals from key decode; bit 1 selects clip 1, bit 0 selects clip 0.
REQ-010 SHALL have port ram_addr  output  ADDR_W  read address to the audio sample RAM.
REQ-011 SHALL have port ram_q  input  16  RAM read data, valid at most 1 Clk after ram_addr changes.
REQ-012 SHALL have port sample  output  24  sample to the codec serializer, {ram_q, 8'h00}.
REQ-013 SHALL have port busy  output  1  high while a clip is playing.
REQ-014 SHALL have port done  output  1  one-Clk pulse when a clip finishes.

Function
REQ-015 SHALL synchronize lrclk with a 2-flop synchronizer and detect a frame edge (sync high, previous sync low).
REQ-016 SHALL detect trig rising edges per bit in the Clk domain; a held level SHALL NOT retrigger.
REQ-017 SHALL implement FSM states IDLE, WAIT_FRAME, READ, LATCH, DRAIN.
REQ-018 IDLE: busy=0, sample=0; a trig edge SHALL load ram_addr with the clip start and go to WAIT_FRAME.
REQ-019 WAIT_FRAME: on frame edge go to READ; READ: one Clk, then LATCH; LATCH: one Clk, sample<=ram_q padded.
REQ-020 From LATCH, ram_addr != clip end: ram_addr<=ram_addr+1, go to WAIT_FRAME.
REQ-021 From LATCH, ram_addr == clip end: go to DRAIN; DRAIN holds the last sample until the next frame edge, then sample<=0, done=1 for one Clk, go to IDLE.
REQ-022 sample SHALL update on the 4th Clk rising edge after the edge that first samples lrclk high.
REQ-023 ram_addr SHALL stay stable from WAIT_FRAME entry through LATCH.
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 Simultaneous trig edges: clip 1 SHALL win.
REQ-026 A trig edge in any non-IDLE state SHALL reload the new clip start and go to WAIT_FRAME; sample holds its value; this SHALL take priority over end-of-clip handling; done SHALL NOT pulse.
REQ-027 Address arithmetic SHALL be ADDR_W bits; END < START is illegal; END = 2^ADDR_W-1 SHALL terminate without wrapping.

Reset
REQ-028 Reset_n low SHALL immediately force state IDLE, ram_addr=0, sample=0, busy=0, done=0, and clear the synchronizer and edge-detect flops (trig history = 0).
REQ-029 Reset mid-clip SHALL abandon playback with no done pulse; a trig level high at reset release SHALL count as an edge.

Configuration
REQ-030 With AUDIO_LOOP_EN defined, end-of-clip with that clip's trig bit still high SHALL reload the clip start and go to WAIT_FRAME (no DRAIN, no done).
REQ-031 Without AUDIO_LOOP_EN, end-of-clip SHALL always follow REQ-021.

Verification
REQ-032 Reset, trig=2'b01 pulse, ram_q=addr-derived pattern, lrclk 48 kHz -> ram_addr 0x0000,0x0001,...; sample={ram_q,8'h00} 4 Clk after each frame.
REQ-033 Clip 0 with CLIP0_END=0x0003 -> exactly 4 samples, DRAIN one frame, sample=0, single done pulse, busy falls the same Clk.
REQ-034 trig=2'b11 in one Clk -> ram_addr=CLIP1_START (0x2000), clip 0 ignored.
REQ-035 Clip 0 at address 0x0010, trig[1] edge -> ram_addr=0x2000 before the next frame, no done pulse, busy stays high.
REQ-036 Reset_n low mid-clip at address 0x0100 -> all outputs 0 asynchronously, no done pulse after release with trig=0.
REQ-037 AUDIO_LOOP_EN, CLIP0_END=0x0003, trig[0] held -> address sequence 0,1,2,3,0,1,...; release -> ends after 3 with done.

Source files
------------

// File: rtl/audio_clip_player_if.sv
// Audio sample RAM read port.
// The player drives the address and the RAM returns the data word.
interface audio_clip_player_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_q;

  modport master (
    output ram_addr,
    input  ram_q
  );

  modport slave (
    input  ram_addr,
    output ram_q
  );
endinterface

// File: rtl/audio_clip_player.sv
// Two-clip audio player: streams RAM words to the codec, one per lrclk frame.
// Optional AUDIO_LOOP_EN: a clip whose trig bit is still held restarts.
module audio_clip_player #(
  parameter int              ADDR_W      = 14,
  parameter logic [ADDR_W-1:0] CLIP0_START = 14'h0000,
  parameter logic [ADDR_W-1:0] CLIP0_END   = 14'h1FFF,
  parameter logic [ADDR_W-1:0] CLIP1_START = 14'h2000,
  parameter logic [ADDR_W-1:0] CLIP1_END   = 14'h3FFF
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                lrclk,
  input  logic [1:0]          trig,
  audio_clip_player_if.master ram,
  output logic [23:0]         sample,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    READ,
    LATCH,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       sample_q, sample_d;
  logic              clip_q, clip_d;
  logic              done_q, done_d;

  logic              sync1_q, sync2_q, frm_q;
  logic [1:0]        trig_q;

  logic              frame_edge;
  logic [1:0]        trig_edge;
  logic [ADDR_W-1:0] clip_start;
  logic [ADDR_W-1:0] clip_end;
  logic              loop_hold;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      frm_q   <= 1'b0;
      trig_q  <= 2'b00;
    end else begin
      sync1_q <= lrclk;
      sync2_q <= sync1_q;
      frm_q   <= sync2_q;
      trig_q  <= trig;
    end
  end

  assign frame_edge = sync2_q & ~frm_q;
  assign trig_edge  = trig & ~trig_q;

  assign clip_start = clip_q ? CLIP1_START : CLIP0_START;
  assign clip_end   = clip_q ? CLIP1_END   : CLIP0_END;

`ifdef AUDIO_LOOP_EN
  assign loop_hold = clip_q ? trig[1] : trig[0];
`else
  assign loop_hold = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      sample_q <= '0;
      clip_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      clip_q   <= clip_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    clip_d   = clip_q;
    done_d   = 1'b0;
    // A new request preempts everything, including end-of-clip.
    if (|trig_edge) begin
      clip_d  = trig_edge[1];
      addr_d  = trig_edge[1] ? CLIP1_START : CLIP0_START;
      state_d = WAIT_FRAME;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        WAIT_FRAME: begin
          if (frame_edge) state_d = READ;
        end
        READ: begin
          state_d = LATCH;
        end
        LATCH: begin
          sample_d = {ram.ram_q, 8'h00};
          if (addr_q != clip_end) begin
            addr_d  = addr_q + 1'b1;
            state_d = WAIT_FRAME;
          end else if (loop_hold) begin
            addr_d  = clip_start;
            state_d = WAIT_FRAME;
          end else begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (frame_edge) begin
            sample_d = '0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign ram.ram_addr = addr_q;
  assign sample       = sample_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule
